// File: rtl/spram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a pair of 16-bit SPRAM macros.
// Data wins by default; a starved instruction request is forced through after STARVE_LIMIT losses.
module spram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [13:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [7:0]  ram_maskwren,
    output logic        ram_wren,
    output logic        ram_cs,
    output logic        ram_standby,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {StActive, StStandby, StWake} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           i_rvalid_q, d_rvalid_q;
    logic           active, i_win, d_win, idle_cycle;

    // Grants and RAM strobes are combinational so a request is serviced in its own cycle.
    always_comb begin
        active = (state_q == StActive) && !reset;
        i_win  = active && i_req && (!d_req || (starve_q == SW'(STARVE_LIMIT)));
        d_win  = active && d_req && !i_win;

        i_gnt        = i_win;
        d_gnt        = d_win;
        ram_cs       = i_win || d_win;
        ram_addr     = i_win ? i_addr : d_addr;
        ram_wdata    = d_wdata;
        ram_wren     = d_win && d_we && (d_be != 4'b0000);
        ram_maskwren = 8'h00;
        for (int b = 0; b < 4; b++) begin
            ram_maskwren[2*b +: 2] = {2{d_win && d_we && d_be[b]}};
        end
        ram_standby  = (state_q == StStandby) && !reset;
        // A response registered just before reset must not leak out during it.
        i_rvalid     = i_rvalid_q && !reset;
        d_rvalid     = d_rvalid_q && !reset;
        i_rdata      = ram_rdata;
        d_rdata      = ram_rdata;
    end

    always_comb begin
        state_d    = state_q;
        idle_d     = '0;
        starve_d   = starve_q;
        idle_cycle = !i_req && !d_req && !i_rvalid_q && !d_rvalid_q;

        if (!i_req || i_win) begin
            starve_d = '0;
        end else if ((state_q == StActive) && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end

        unique case (state_q)
            StActive: begin
                if (idle_cycle) begin
                    if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                        state_d = StStandby;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            StStandby: begin
                if (i_req || d_req) begin
                    state_d = StWake;
                end
            end
            StWake: begin
                state_d = StActive;
            end
            default: begin
                state_d = StActive;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StActive;
            starve_q   <= '0;
            idle_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            idle_q     <= idle_d;
            i_rvalid_q <= i_win;
            d_rvalid_q <= d_win && !d_we;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model of the arbiter.
module tb_spram_arbiter;

    localparam int LIM = 4;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [13:0] i_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata, ram_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata, ram_wdata;
    logic [13:0] ram_addr;
    logic [7:0]  ram_maskwren;
    logic        ram_wren, ram_cs, ram_standby;

    int n_tests = 0;
    int n_fail  = 0;

    spram_arbiter #(.STARVE_LIMIT(LIM), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_maskwren(ram_maskwren),
        .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // {i_gnt, d_gnt, ram_cs, ram_wren, ram_standby, i_rvalid, d_rvalid}
    function automatic logic [6:0] ctl();
        return {i_gnt, d_gnt, ram_cs, ram_wren, ram_standby, i_rvalid, d_rvalid};
    endfunction

    task automatic idle_in();
        i_req = 0; d_req = 0; d_we = 0; d_be = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; ram_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1;
        i_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({ctl(), ram_maskwren} !== 15'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ctl=%b mask=%h want ctl=0 mask=00",
                         k, ctl(), ram_maskwren);
            end
            tick();
        end
        reset = 0;
        idle_in();
    endtask

    task automatic test_write_mask();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 14'h0010; d_wdata = 32'hAABBCCDD; d_be = 4'b0101;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_maskwren} !== {7'b0111000, 8'h33}) begin
            n_fail++;
            $display("FAIL write_strobes: got ctl=%b mask=%h want ctl=0111000 mask=33",
                     ctl(), ram_maskwren);
        end
        n_tests++;
        if ({ram_addr, ram_wdata} !== {14'h0010, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL write_bus: got addr=%h wdata=%h want 0010 aabbccdd", ram_addr, ram_wdata);
        end
        tick();
        d_we = 0;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_maskwren} !== {7'b0110000, 8'h00}) begin
            n_fail++;
            $display("FAIL readback_grant: got ctl=%b mask=%h want ctl=0110000 mask=00",
                     ctl(), ram_maskwren);
        end
        tick();
        idle_in();
        ram_rdata = 32'hAABBCCDD;
        @(negedge clk);
        n_tests++;
        if ({ctl(), d_rdata} !== {7'b0000001, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL readback_data: got ctl=%b rdata=%h want ctl=0000001 rdata=aabbccdd",
                     ctl(), d_rdata);
        end
        tick();
        d_req = 1; d_we = 1; d_be = 4'b0000;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_maskwren} !== {7'b0110000, 8'h00}) begin
            n_fail++;
            $display("FAIL empty_be_write: got ctl=%b mask=%h want ctl=0110000 mask=00",
                     ctl(), ram_maskwren);
        end
        tick();
        idle_in();
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL empty_be_no_rvalid: got ctl=%b want 0000000", ctl());
        end
        tick();
    endtask

    task automatic test_starve();
        logic ei;
        do_reset();
        i_req = 1; d_req = 1; d_we = 0; i_addr = 14'h0001; d_addr = 14'h0002;
        for (int k = 0; k < 10; k++) begin
            ei = ((k % 5) == 4);
            @(negedge clk);
            n_tests++;
            if ({i_gnt, d_gnt, ram_addr} !== {ei, !ei, ei ? 14'h0001 : 14'h0002}) begin
                n_fail++;
                $display("FAIL starve_cycle%0d: got i_gnt=%b d_gnt=%b addr=%h want i_gnt=%b",
                         k, i_gnt, d_gnt, ram_addr, ei);
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 1; i_addr = 14'h0003;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_addr} !== {7'b1010000, 14'h0003}) begin
            n_fail++;
            $display("FAIL b2b_i_grant: got ctl=%b addr=%h want 1010000 0003", ctl(), ram_addr);
        end
        tick();
        i_req = 0; d_req = 1; d_we = 0; d_addr = 14'h0004; ram_rdata = 32'h11112222;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_addr, i_rdata} !== {7'b0110010, 14'h0004, 32'h11112222}) begin
            n_fail++;
            $display("FAIL b2b_d_grant: got ctl=%b addr=%h i_rdata=%h want 0110010 0004 11112222",
                     ctl(), ram_addr, i_rdata);
        end
        tick();
        idle_in();
        ram_rdata = 32'h33334444;
        @(negedge clk);
        n_tests++;
        if ({ctl(), d_rdata} !== {7'b0000001, 32'h33334444}) begin
            n_fail++;
            $display("FAIL b2b_d_rvalid: got ctl=%b d_rdata=%h want 0000001 33334444",
                     ctl(), d_rdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL b2b_quiet: got ctl=%b want 0000000", ctl());
        end
        tick();
    endtask

    task automatic test_standby();
        do_reset();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            n_tests++;
            if (ram_standby !== 1'b0) begin
                n_fail++;
                $display("FAIL standby_early[%0d]: got %b want 0", k, ram_standby);
            end
            tick();
        end
        i_req = 1; i_addr = 14'h0007;
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0000100) begin
            n_fail++;
            $display("FAIL standby_entered: got ctl=%b want 0000100", ctl());
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL wake_cycle: got ctl=%b want 0000000", ctl());
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_addr} !== {7'b1010000, 14'h0007}) begin
            n_fail++;
            $display("FAIL wake_grant: got ctl=%b addr=%h want 1010000 0007", ctl(), ram_addr);
        end
        tick();
        idle_in();
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0000010) begin
            n_fail++;
            $display("FAIL wake_rvalid: got ctl=%b want 0000010", ctl());
        end
        tick();
    endtask

    task automatic test_reset_midread();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 14'h0005;
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0110000) begin
            n_fail++;
            $display("FAIL midread_grant: got ctl=%b want 0110000", ctl());
        end
        tick();
        idle_in();
        reset = 1;
        @(negedge clk);
        n_tests++;
        if ({ctl(), ram_maskwren} !== 15'h0) begin
            n_fail++;
            $display("FAIL midread_reset: got ctl=%b mask=%h want 0", ctl(), ram_maskwren);
        end
        tick();
        reset = 0;
        @(negedge clk);
        n_tests++;
        if (ctl() !== 7'b0) begin
            n_fail++;
            $display("FAIL midread_after: got ctl=%b want 0000000", ctl());
        end
        tick();
    endtask

    task automatic test_random();
        int         mode, starve, idle;  // mode: 0 active, 1 standby, 2 wake
        bit         pi, pd, ei, ed, act, idle_c, quiet, wr;
        logic [6:0] exp_ctl;
        logic [7:0] exp_mask;
        do_reset();
        mode = 0; starve = 0; idle = 0; pi = 0; pd = 0; ei = 0; ed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            quiet = (cyc % 120) >= 85;
            // Requests stay asserted with stable payload until granted.
            if (!(i_req && !ei)) begin
                i_req  = !quiet && ($urandom_range(0, 2) == 0);
                i_addr = 14'($urandom);
            end
            if (!(d_req && !ed)) begin
                d_req   = !quiet && ($urandom_range(0, 1) == 0);
                d_we    = 1'($urandom);
                d_be    = 4'($urandom);
                d_addr  = 14'($urandom);
                d_wdata = $urandom;
            end
            ram_rdata = $urandom;
            reset     = ($urandom_range(0, 99) == 0);

            act = !reset && (mode == 0);
            ei  = act && i_req && (!d_req || starve == LIM);
            ed  = act && d_req && !ei;
            wr  = ed && d_we;
            for (int b = 0; b < 4; b++) exp_mask[2*b +: 2] = (wr && d_be[b]) ? 2'b11 : 2'b00;
            exp_ctl = {ei, ed, ei || ed, wr && (d_be != 0), !reset && mode == 1,
                       !reset && pi, !reset && pd};

            @(negedge clk);
            n_tests++;
            if ({ctl(), ram_maskwren} !== {exp_ctl, exp_mask}) begin
                n_fail++;
                $display("FAIL rand_ctl cyc%0d: got ctl=%b mask=%h want ctl=%b mask=%h",
                         cyc, ctl(), ram_maskwren, exp_ctl, exp_mask);
            end
            if (ei || ed) begin
                n_tests++;
                if (ram_addr !== (ei ? i_addr : d_addr)) begin
                    n_fail++;
                    $display("FAIL rand_addr cyc%0d: got %h want %h",
                             cyc, ram_addr, ei ? i_addr : d_addr);
                end
            end
            if (wr) begin
                n_tests++;
                if (ram_wdata !== d_wdata) begin
                    n_fail++;
                    $display("FAIL rand_wdata cyc%0d: got %h want %h", cyc, ram_wdata, d_wdata);
                end
            end
            if (exp_ctl[1] || exp_ctl[0]) begin
                n_tests++;
                if ((exp_ctl[1] ? i_rdata : d_rdata) !== ram_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc%0d: got i=%h d=%h want %h",
                             cyc, i_rdata, d_rdata, ram_rdata);
                end
            end

            if (reset) begin
                mode = 0; starve = 0; idle = 0; pi = 0; pd = 0;
            end else begin
                idle_c = !i_req && !d_req && !pi && !pd;
                if (!i_req || ei) starve = 0;
                else if (mode == 0 && starve < LIM) starve++;
                case (mode)
                    0: begin
                        if (idle_c) begin
                            idle++;
                            if (idle == TO) begin
                                mode = 1;
                                idle = 0;
                            end
                        end else begin
                            idle = 0;
                        end
                    end
                    1: if (i_req || d_req) mode = 2;
                    default: mode = 0;
                endcase
                pi = ei;
                pd = ed && !d_we;
            end
            tick();
        end
        reset = 0;
        idle_in();
    endtask

    initial begin
        idle_in();
        reset = 1;
        test_reset();
        test_write_mask();
        test_starve();
        test_back_to_back();
        test_standby();
        test_reset_midread();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
